// File: rtl/scan_mux_nway.sv
// Time-multiplexed N-way channel selector with masked auto scan,
// manual pinning, inter-slot blanking and a slot strobe.
module scan_mux_nway #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_CYC = 1000,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_CH*DATA_W-1:0] IN_BUS,
    input  logic [NUM_CH-1:0]        CH_EN,
    input  logic                     MODE,
    input  logic [SEL_W-1:0]         SEL,
    output logic [DATA_W-1:0]        OUT,
    output logic [NUM_CH-1:0]        ANODE,
    output logic                     STROBE
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYC);

    logic             run;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic             tick, found, en_nxt;
    int               j;

    always_comb begin
        cnt_nxt = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        j       = 0;
        tick    = run && (cnt == LAST);
        if (run && (cnt != LAST))
            cnt_nxt = cnt + 1'b1;
        // first edge after release parks on channel 0 at cnt 0
        if (!run) begin
            ptr_nxt = '0;
        end else if (tick && MODE) begin
            ptr_nxt = SEL;
        end else if (tick) begin
            for (int k = 1; k < NUM_CH; k++) begin
                j = (int'(ptr) + k) % NUM_CH;
                if (!found && CH_EN[j]) begin
                    ptr_nxt = SEL_W'(j);
                    found   = 1'b1;
                end
            end
        end
        en_nxt = (int'(ptr_nxt) < NUM_CH) && CH_EN[ptr_nxt];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            run    <= 1'b0;
            cnt    <= '0;
            ptr    <= '0;
            OUT    <= '0;
            ANODE  <= '1;
            STROBE <= 1'b0;
        end else begin
            run    <= 1'b1;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            STROBE <= (cnt_nxt == '0);
            if (en_nxt)
                OUT <= IN_BUS[int'(ptr_nxt)*DATA_W +: DATA_W];
            else
                OUT <= '0;
            if (en_nxt && (cnt_nxt >= BLANK))
                ANODE <= ~(NUM_CH'(1) << ptr_nxt);
            else
                ANODE <= '1;
        end
    end

endmodule
